// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs incoming code bytes into DATA_WIDTH
// windows and writes them to instruction memory, guarding the memory capacity.
module instr_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOG_WIN    = 2,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              s_byte,
    input  logic                    s_vld,
    input  logic                    s_last,
    output logic                    s_rdy,
    output logic                    we,
    output logic [LOG_WIN-1:0]      write_pointer_shift_minusone,
    output logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_stall,
    output logic [ADDR_WIDTH:0]     byte_count,
    output logic                    load_done,
    output logic                    overflow_err
);

    localparam int unsigned WIN_BYTES = DATA_WIDTH / 8;
    localparam int unsigned FILL_W    = LOG_WIN + 1;
    localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
    localparam int unsigned SUM_W     = ADDR_WIDTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state,      state_d;
    logic [FILL_W-1:0]     fill_cnt,   fill_cnt_d;
    logic                  has_last,   has_last_d;
    logic                  ovf_pend,   ovf_pend_d;
    logic                  s_rdy_d;
    logic                  we_d;
    logic [LOG_WIN-1:0]    shift_d;
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic [CNT_W-1:0]      byte_count_d;
    logic                  load_done_d;
    logic                  overflow_err_d;
    logic [FILL_W-1:0]     fill_next;
    logic [SUM_W-1:0]      sum_next;
    logic                  ovf_next;

    // State and registered outputs; wr_data doubles as the window assembly buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                        <= S_IDLE;
            fill_cnt                     <= '0;
            has_last                     <= 1'b0;
            ovf_pend                     <= 1'b0;
            s_rdy                        <= 1'b0;
            we                           <= 1'b0;
            write_pointer_shift_minusone <= '0;
            wr_data                      <= '0;
            byte_count                   <= '0;
            load_done                    <= 1'b0;
            overflow_err                 <= 1'b0;
        end else begin
            state                        <= state_d;
            fill_cnt                     <= fill_cnt_d;
            has_last                     <= has_last_d;
            ovf_pend                     <= ovf_pend_d;
            s_rdy                        <= s_rdy_d;
            we                           <= we_d;
            write_pointer_shift_minusone <= shift_d;
            wr_data                      <= wr_data_d;
            byte_count                   <= byte_count_d;
            load_done                    <= load_done_d;
            overflow_err                 <= overflow_err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state;
        fill_cnt_d     = fill_cnt;
        has_last_d     = has_last;
        ovf_pend_d     = ovf_pend;
        s_rdy_d        = s_rdy;
        we_d           = we;
        shift_d        = write_pointer_shift_minusone;
        wr_data_d      = wr_data;
        byte_count_d   = byte_count;
        load_done_d    = load_done;
        overflow_err_d = overflow_err;
        fill_next      = fill_cnt + FILL_W'(1);
        sum_next       = SUM_W'(byte_count) + SUM_W'(fill_next);
        ovf_next       = (sum_next > SUM_W'(DEPTH));

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_FILL;
                    fill_cnt_d     = '0;
                    has_last_d     = 1'b0;
                    ovf_pend_d     = 1'b0;
                    s_rdy_d        = 1'b1;
                    we_d           = 1'b0;
                    shift_d        = '0;
                    wr_data_d      = '0;
                    byte_count_d   = '0;
                    load_done_d    = 1'b0;
                    overflow_err_d = 1'b0;
                end
            end

            S_FILL: begin
                if (s_vld && s_rdy) begin
                    for (int unsigned i = 0; i < WIN_BYTES; i++) begin
                        if (fill_cnt == FILL_W'(i)) begin
                            wr_data_d[i*8 +: 8] = s_byte;
                        end
                    end
                    fill_cnt_d = fill_next;
                    // Window closes on a full lane set or on the final byte.
                    if (fill_next == FILL_W'(WIN_BYTES) || s_last) begin
                        state_d    = S_EMIT;
                        s_rdy_d    = 1'b0;
                        has_last_d = s_last;
                        shift_d    = LOG_WIN'(fill_cnt);
                        ovf_pend_d = ovf_next;
                        we_d       = !ovf_next;
                    end
                end
            end

            S_EMIT: begin
                if (ovf_pend) begin
                    // Capacity exceeded: drop this window and end the load.
                    state_d        = S_DONE;
                    ovf_pend_d     = 1'b0;
                    we_d           = 1'b0;
                    fill_cnt_d     = '0;
                    wr_data_d      = '0;
                    shift_d        = '0;
                    overflow_err_d = 1'b1;
                    load_done_d    = 1'b1;
                end else if (!wr_stall) begin
                    byte_count_d = byte_count + CNT_W'(fill_cnt);
                    fill_cnt_d   = '0;
                    wr_data_d    = '0;
                    shift_d      = '0;
                    we_d         = 1'b0;
                    if (has_last) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = S_FILL;
                        s_rdy_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a small capacity (DEPTH=8) so the
// overflow path is reachable alongside the normal load scenarios.
module tb_instr_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  s_byte;
    logic        s_vld;
    logic        s_last;
    logic        s_rdy;
    logic        we;
    logic [1:0]  shm1;
    logic [31:0] wr_data;
    logic        wr_stall;
    logic [10:0] byte_count;
    logic        load_done;
    logic        overflow_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] cq[$];
    logic [1:0]  sq[$];
    logic [31:0] held;

    instr_loader #(
        .DATA_WIDTH(32), .LOG_WIN(2), .ADDR_WIDTH(10), .DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_byte(s_byte),
        .s_vld(s_vld), .s_last(s_last), .s_rdy(s_rdy), .we(we),
        .write_pointer_shift_minusone(shm1), .wr_data(wr_data),
        .wr_stall(wr_stall), .byte_count(byte_count),
        .load_done(load_done), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every committed write (we high and not stalled going into the edge).
    always @(negedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1 && wr_stall === 1'b0) begin
            cq.push_back(wr_data);
            sq.push_back(shm1);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        s_byte = b;
        s_last = last;
        s_vld  = 1'b1;
        while (s_rdy !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("s_rdy_wait", 64'(s_rdy), 64'd1);
        tick();
        s_vld  = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (load_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("load_done", 64'(load_done), 64'd1);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_s_rdy"}, 64'(s_rdy), 64'd0);
        check({pfx, "_we"}, 64'(we), 64'd0);
        check({pfx, "_shm1"}, 64'(shm1), 64'd0);
        check({pfx, "_wr_data"}, 64'(wr_data), 64'd0);
        check({pfx, "_byte_count"}, 64'(byte_count), 64'd0);
        check({pfx, "_load_done"}, 64'(load_done), 64'd0);
        check({pfx, "_overflow_err"}, 64'(overflow_err), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; s_byte = 8'h00; s_vld = 1'b0;
        s_last = 1'b0; wr_stall = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle_s_rdy", 64'(s_rdy), 64'd0);

        // Single full window carrying s_last.
        cq.delete(); sq.delete();
        do_start();
        check("a_fill_s_rdy", 64'(s_rdy), 64'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h73, 1'b0);
        send_byte(8'h6D, 1'b1);
        check("a_emit_we", 64'(we), 64'd1);
        check("a_emit_s_rdy", 64'(s_rdy), 64'd0);
        check("a_emit_data", 64'(wr_data), 64'h6D736100);
        check("a_emit_shm1", 64'(shm1), 64'd3);
        wait_done();
        check("a_byte_count", 64'(byte_count), 64'd4);
        check("a_we_after", 64'(we), 64'd0);
        check("a_commits", 64'(cq.size()), 64'd1);

        // Full window then a 2-byte tail.
        cq.delete(); sq.delete();
        do_start();
        check("b_restart_done", 64'(load_done), 64'd0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        check("b_w1_we", 64'(we), 64'd1);
        check("b_w1_s_rdy", 64'(s_rdy), 64'd0);
        check("b_w1_data", 64'(wr_data), 64'h04030201);
        check("b_w1_shm1", 64'(shm1), 64'd3);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b1);
        check("b_w2_we", 64'(we), 64'd1);
        check("b_w2_s_rdy", 64'(s_rdy), 64'd0);
        check("b_w2_data", 64'(wr_data), 64'h00000605);
        check("b_w2_shm1", 64'(shm1), 64'd1);
        wait_done();
        check("b_byte_count", 64'(byte_count), 64'd6);
        check("b_commits", 64'(cq.size()), 64'd2);
        if (cq.size() == 2) begin
            check("b_q0_data", 64'(cq[0]), 64'h04030201);
            check("b_q1_data", 64'(cq[1]), 64'h00000605);
            check("b_q1_shm1", 64'(sq[1]), 64'd1);
        end

        // Memory stall for three cycles in EMIT.
        cq.delete(); sq.delete();
        do_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        wr_stall = 1'b1;
        send_byte(8'hDD, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("c_stall_we", 64'(we), 64'd1);
            check("c_stall_data", 64'(wr_data), 64'hDDCCBBAA);
            check("c_stall_shm1", 64'(shm1), 64'd3);
            check("c_stall_count", 64'(byte_count), 64'd0);
            tick();
        end
        check("c_last_we", 64'(we), 64'd1);
        check("c_last_data", 64'(wr_data), 64'hDDCCBBAA);
        wr_stall = 1'b0;
        tick();
        check("c_done", 64'(load_done), 64'd1);
        check("c_byte_count", 64'(byte_count), 64'd4);
        check("c_commits", 64'(cq.size()), 64'd1);

        // Overflow: 12 bytes into an 8-byte memory.
        cq.delete(); sq.delete();
        do_start();
        for (int i = 0; i < 12; i++) begin
            send_byte(8'(8'h10 + i), (i == 11));
            if (i == 11) begin
                check("d_w3_we", 64'(we), 64'd0);
                check("d_w3_s_rdy", 64'(s_rdy), 64'd0);
            end
        end
        wait_done();
        check("d_overflow_err", 64'(overflow_err), 64'd1);
        check("d_byte_count", 64'(byte_count), 64'd8);
        check("d_commits", 64'(cq.size()), 64'd2);
        if (cq.size() == 2) check("d_q1_data", 64'(cq[1]), 64'h17161514);

        // Reset in the middle of a window, then a fresh load.
        cq.delete(); sq.delete();
        do_start();
        check("e_start_clr_ovf", 64'(overflow_err), 64'd0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        check("e_partial_buf", 64'(wr_data), 64'h00000201);
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        tick();
        check("e_idle_s_rdy", 64'(s_rdy), 64'd0);
        do_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_done();
        check("e_byte_count", 64'(byte_count), 64'd4);
        check("e_commits", 64'(cq.size()), 64'd1);
        if (cq.size() == 1) check("e_q0_data", 64'(cq[0]), 64'h44332211);

        // Gapped s_vld with start pulses during FILL.
        cq.delete(); sq.delete();
        do_start();
        for (int i = 0; i < 4; i++) begin
            held = 32'h6D736100;
            send_byte(held[i*8 +: 8], (i == 3));
            if (i < 3) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check("f_gap_s_rdy", 64'(s_rdy), 64'd1);
                check("f_gap_we", 64'(we), 64'd0);
            end
        end
        check("f_emit_data", 64'(wr_data), 64'h6D736100);
        wait_done();
        check("f_byte_count", 64'(byte_count), 64'd4);
        check("f_commits", 64'(cq.size()), 64'd1);
        if (cq.size() == 1) check("f_q0_data", 64'(cq[0]), 64'h6D736100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, write window width (8*WIN_BYTES); LOG_WIN, 2, log2 of WIN_BYTES; ADDR_WIDTH, 10, instruction memory address width; DEPTH, 1024, instruction memory capacity in bytes.
REQ-002 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  begin a load; honoured only in IDLE or DONE.
REQ-005 s_byte  input  8  incoming code byte.
REQ-006 s_vld  input  1  s_byte valid.
REQ-007 s_last  input  1  s_byte is the final byte of the load; qualified by s_vld.
REQ-008 s_rdy  output  1  loader accepts s_byte this cycle.
REQ-009 we  output  1  write request to instruction memory write port.
REQ-010 write_pointer_shift_minusone  output  LOG_WIN  valid bytes in wr_data minus one.
REQ-011 wr_data  output  DATA_WIDTH  packed bytes; lowest-address byte in bits [7:0].
REQ-012 wr_stall  input  1  memory cannot take the write this cycle.
REQ-013 byte_count  output  ADDR_WIDTH+1  total bytes committed to memory.
REQ-014 load_done  output  1  level, high in DONE.
REQ-015 overflow_err  output  1  sticky until next start, load exceeded DEPTH.

Function
REQ-016 SHALL implement states IDLE, FILL, EMIT, DONE.
REQ-017 IDLE: s_rdy=0, we=0; start -> FILL with fill count 0, byte_count 0, overflow_err 0.
REQ-018 FILL: s_rdy=1; byte accepted on s_vld&s_rdy, written to byte lane fill_cnt, fill_cnt+1.
REQ-019 FILL -> EMIT on the cycle a byte is accepted that makes fill_cnt reach WIN_BYTES, or any accepted byte with s_last=1; a byte with s_last=1 is always counted.
REQ-020 EMIT: s_rdy=0, we=1 the cycle after the completing byte is accepted (latency 1); write_pointer_shift_minusone = n-1, n = bytes in window; unused lanes of wr_data = 0.
REQ-021 EMIT with wr_stall=1: we, wr_data, write_pointer_shift_minusone held stable; no state change.
REQ-022 EMIT with wr_stall=0: write committed; byte_count += n; fill_cnt cleared; -> DONE if window held s_last, else -> FILL.
REQ-023 Overflow: in EMIT, if byte_count+n > DEPTH, we SHALL be 0, nothing committed, overflow_err set, -> DONE next cycle.
REQ-024 DONE: load_done=1, s_rdy=0, we=0; start -> FILL with counters and overflow_err cleared, load_done 0.
REQ-025 start in FILL or EMIT SHALL be ignored.
REQ-026 s_vld gaps in FILL SHALL only stall packing, never emit a partial window without s_last.
REQ-027 byte_count arithmetic SHALL be ADDR_WIDTH+1 bits unsigned; it never exceeds DEPTH.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, fill_cnt 0, and all outputs 0 (s_rdy, we, write_pointer_shift_minusone, wr_data, byte_count, load_done, overflow_err), from any state including mid-FILL/EMIT; partial window discarded.

Verification
REQ-029 start; bytes 00,61,73,6D, s_last on 4th -> one we pulse, wr_data 0x6D736100, shift_minusone 3, byte_count 4, load_done 1.
REQ-030 bytes 01..06, s_last on 6th -> writes 0x04030201/3 then 0x00000605/1; byte_count 6; s_rdy 0 during each EMIT.
REQ-031 wr_stall=1 for 3 cycles in EMIT -> we high with stable wr_data 4 cycles total, single commit, byte_count +4 only.
REQ-032 DEPTH=8, 12 bytes streamed -> two writes, third window suppressed (we 0), overflow_err 1, byte_count 8, load_done 1.
REQ-033 rst_n low after 2 bytes accepted -> next cycle all outputs 0, IDLE; fresh start load of 4 bytes gives byte_count 4.
REQ-034 s_vld toggling every other cycle over 4 bytes -> exactly one write, identical data to contiguous stream; start asserted during FILL has no effect.
